hamming_enc_seq: RTL and testbench

- Hardware sequencer for program 1 (Hamming(16,11) SECDED encode). It walks data memory, reads NUM_MSG 11-bit messages stored as byte pairs, computes the parity bits, and writes the 16-bit encoded words back.
- Sits beside the core in top_level and drives the data-memory port while busy. It starts on req and reports completion on done, matching the top_level req/done handshake.

---
 rtl/hamming_enc_seq_if.sv | 23 ++
 rtl/hamming_enc_seq.sv | 122 ++++++++++++
 tb/tb_hamming_enc_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/hamming_enc_seq_if.sv
// Handshake and data-memory port between the Hamming(16,11) encode sequencer and top_level.
interface hamming_enc_seq_if #(
    parameter int AW = 8
);
    logic          req;
    logic          done;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_dat;
    logic [7:0]    mem_rd_dat;

    // master: the sequencer, which owns the memory port while busy
    modport master (
        input  req, mem_rd_dat,
        output done, busy, mem_addr, mem_wr_en, mem_wr_dat
    );

    modport slave (
        output req, mem_rd_dat,
        input  done, busy, mem_addr, mem_wr_en, mem_wr_dat
    );
endinterface

// File: rtl/hamming_enc_seq.sv
// Sequencer that reads NUM_MSG 11-bit messages from data memory, Hamming(16,11)
// SECDED encodes them and writes the 16-bit code words back, high byte first.
module hamming_enc_seq #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    hamming_enc_seq_if.master bus
);
    localparam int CW = $clog2(NUM_MSG) + 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_LO = 3'd1;
    localparam logic [2:0] RD_HI = 3'd2;
    localparam logic [2:0] WR_HI = 3'd3;
    localparam logic [2:0] WR_LO = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [CW-1:0] LAST_MSG = CW'(NUM_MSG - 1);
    localparam logic [AW-1:0] SRC_A    = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A    = AW'(DST_BASE);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] i_q, i_d;
    logic [7:0]    lo_q, lo_d;
    logic [2:0]    hi_q, hi_d;

    // d[11:1] of the message; index 0 is unused so bit numbers match the code layout
    logic [11:1] d;
    logic        p8, p4, p2, p1, p0;
    logic [AW-1:0] pair_off;

    assign d        = {hi_q, lo_q};
    assign pair_off = AW'({i_q, 1'b0});

    assign p8 = ^d[11:5];
    assign p4 = (^d[11:8]) ^ (^d[4:2]);
    assign p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    assign p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    assign p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    state_d = RD_LO;
                    i_d     = '0;
                end
            end
            RD_LO: begin
                lo_d    = bus.mem_rd_dat;
                state_d = RD_HI;
            end
            RD_HI: begin
                hi_d    = bus.mem_rd_dat[2:0];
                state_d = WR_HI;
            end
            WR_HI: state_d = WR_LO;
            WR_LO: begin
                if (i_q == LAST_MSG) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = RD_LO;
                end
            end
            DONE: begin
                if (bus.req) begin
                    state_d = RD_LO;
                    i_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            i_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // Memory port is a pure decode of state so reads see the address in the same cycle
    always_comb begin
        bus.mem_addr   = '0;
        bus.mem_wr_en  = 1'b0;
        bus.mem_wr_dat = '0;
        case (state_q)
            RD_LO: bus.mem_addr = SRC_A + pair_off;
            RD_HI: bus.mem_addr = SRC_A + pair_off + 1'b1;
            WR_HI: begin
                bus.mem_addr   = DST_A + pair_off + 1'b1;
                bus.mem_wr_en  = 1'b1;
                bus.mem_wr_dat = {d[11:5], p8};
            end
            WR_LO: begin
                bus.mem_addr   = DST_A + pair_off;
                bus.mem_wr_en  = 1'b1;
                bus.mem_wr_dat = {d[4:2], p4, d[1], p2, p1, p0};
            end
            default: ;
        endcase
    end

    assign bus.done = (state_q == DONE);
    assign bus.busy = (state_q != IDLE) && (state_q != DONE);
endmodule

// File: tb/tb_hamming_enc_seq.sv
// Randomised bench for hamming_enc_seq: a positional Hamming model builds the expected
// destination image, and every write and the final memory contents are compared to it.
module tb_hamming_enc_seq;
    localparam int NUM_MSG = 15;
    localparam int DST     = 30;

    logic clk = 1'b0;
    logic reset;
    logic clr_dst;
    int   total  = 0;
    int   passed = 0;

    logic [7:0] src     [256];
    logic [7:0] dmem    [256];
    logic [7:0] exp_img [256];

    always #5 clk = ~clk;

    hamming_enc_seq_if #(.AW(8)) bus ();

    hamming_enc_seq #(
        .NUM_MSG (NUM_MSG),
        .SRC_BASE(0),
        .DST_BASE(DST),
        .AW      (8)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    assign bus.mem_rd_dat = src[bus.mem_addr];

    always @(posedge clk) begin
        if (clr_dst) begin
            for (int a = 0; a < 256; a++) dmem[a] <= 8'hAA;
        end else if (bus.mem_wr_en) begin
            dmem[bus.mem_addr] <= bus.mem_wr_dat;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Classic Hamming layout: code bit k is position k, parities at powers of two, bit 0 overall
    function automatic logic [15:0] enc(input logic [10:0] m);
        logic [15:0] cw;
        int k;
        cw = '0;
        k  = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = m[k];
                k++;
            end
        end
        for (int j = 1; j < 16; j = j * 2) begin
            for (int pos = 1; pos < 16; pos++)
                if (((pos & j) != 0) && (pos != j)) cw[j] = cw[j] ^ cw[pos];
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    task automatic build_exp();
        logic [15:0] w;
        for (int a = 0; a < 256; a++) exp_img[a] = 8'hAA;
        for (int m = 0; m < NUM_MSG; m++) begin
            w = enc({src[2*m+1][2:0], src[2*m]});
            exp_img[DST+2*m]   = w[7:0];
            exp_img[DST+2*m+1] = w[15:8];
        end
    endtask

    task automatic rand_src();
        for (int a = 0; a < 2*NUM_MSG; a++) src[a] = 8'($urandom);
    endtask

    task automatic clear_dst();
        @(negedge clk) clr_dst = 1'b1;
        @(negedge clk) clr_dst = 1'b0;
    endtask

    // Every write must land in the destination window and carry the modelled byte
    always @(negedge clk) begin
        if (bus.mem_wr_en) begin
            chk("wr_in_dst", 32'((bus.mem_addr >= 8'(DST)) && (bus.mem_addr < 8'(DST + 2*NUM_MSG))), 32'd1);
            chk("wr_data", 32'(bus.mem_wr_dat), 32'(exp_img[bus.mem_addr]));
            chk("wr_while_busy", 32'(bus.busy), 32'd1);
        end
    end

    // Edge count starts at 1 on the edge that samples req
    task automatic run_chk(input string nm, input bit mid_req, input int abort_at);
        int n;
        clear_dst();
        build_exp();
        @(negedge clk) bus.req = 1'b1;
        @(posedge clk);
        n = 1;
        #1 bus.req = 1'b0;
        chk({nm, "_start"}, 32'({bus.done, bus.busy}), 32'b01);
        while (!bus.done && n < 200) begin
            if (abort_at != 0 && n == abort_at) begin
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                chk({nm, "_abort_state"},
                    32'({bus.done, bus.busy, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_dat}), 32'd0);
                #20;
                chk({nm, "_abort_idle"}, 32'({bus.done, bus.busy}), 32'd0);
                for (int a = DST; a < DST + 14; a++)
                    chk({nm, "_kept"}, 32'(dmem[a]), 32'(exp_img[a]));
                chk({nm, "_untouched"}, 32'(dmem[DST+14]), 32'hAA);
                return;
            end
            bus.req = (mid_req && n == 20);
            @(posedge clk);
            n++;
            #1 bus.req = 1'b0;
        end
        chk({nm, "_latency"}, 32'(n), 32'd61);
        chk({nm, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        for (int a = 0; a < 256; a++)
            if (a >= DST && a < DST + 2*NUM_MSG) chk({nm, "_dst"}, 32'(dmem[a]), 32'(exp_img[a]));
            else if (dmem[a] !== 8'hAA) chk({nm, "_outside"}, 32'(dmem[a]), 32'hAA);
    endtask

    initial begin
        reset   = 1'b1;
        clr_dst = 1'b0;
        bus.req = 1'b0;
        for (int a = 0; a < 256; a++) begin
            src[a]     = 8'h00;
            exp_img[a] = 8'hAA;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",
            32'({bus.done, bus.busy, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_dat}), 32'd0);
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        chk("req_under_reset", 32'({bus.done, bus.busy}), 32'd0);
        bus.req = 1'b0;
        reset   = 1'b0;

        chk("model_d1",  32'(enc(11'h001)), 32'h000F);
        chk("model_all", 32'(enc(11'h7FF)), 32'hFFFF);
        chk("model_d11", 32'(enc(11'h400)), 32'h8117);

        run_chk("zeros", 1'b0, 0);

        src[0] = 8'h01;
        src[1] = 8'h00;
        run_chk("d1", 1'b0, 0);
        chk("d1_lo", 32'(dmem[30]), 32'h0F);
        chk("d1_hi", 32'(dmem[31]), 32'h00);

        rand_src();
        src[0] = 8'hFF; src[1] = 8'h07;
        src[2] = 8'h00; src[3] = 8'h04;
        run_chk("ones", 1'b0, 0);
        chk("ones_lo", 32'(dmem[30]), 32'hFF);
        chk("ones_hi", 32'(dmem[31]), 32'hFF);
        chk("d11_lo",  32'(dmem[32]), 32'h17);
        chk("d11_hi",  32'(dmem[33]), 32'h81);

        for (int a = 0; a < 2*NUM_MSG; a += 2) begin
            src[a] = 8'h00; src[a+1] = 8'hF8;
        end
        run_chk("junk", 1'b0, 0);
        chk("junk_w0", 32'({dmem[31], dmem[30]}), 32'h0000);

        rand_src();
        run_chk("abort", 1'b0, 30);
        run_chk("after_abort", 1'b0, 0);

        rand_src();
        run_chk("mid_req", 1'b1, 0);
        rand_src();
        run_chk("restart", 1'b0, 0);
        for (int r = 0; r < 3; r++) begin
            rand_src();
            run_chk("rand", 1'b0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
